// File: rtl/aes_pkg.sv
// Shared AES datapath types: word/block widths and the block type used by
// the packer, the input FIFO and the AES core.
package aes_pkg;
   localparam int WORD_W        = 32;
   localparam int BLK_W         = 128;
   localparam int WORDS_PER_BLK = 4;

   typedef logic [1:0]       word_idx_t;
   typedef logic [BLK_W-1:0] block_t;
endpackage

// File: rtl/aes_word_packer.sv
// Packs 32-bit words (MSW first) into 128-bit AES blocks and writes them to
// the AES input FIFO; an assembly register plus an output register give 1 word/cycle.
module aes_word_packer #(
   parameter int WORD_W = aes_pkg::WORD_W,
   parameter int BLK_W  = aes_pkg::BLK_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              fifo_full,
   output logic              fifo_wr_en,
   output logic [BLK_W-1:0]  fifo_data,
   output logic [CNT_W-1:0]  blk_cnt,
   output logic              busy
);
   import aes_pkg::*;

   localparam int N_WORDS = BLK_W / WORD_W;

   logic [BLK_W-1:0] r_asm;
   logic [BLK_W-1:0] r_obuf;
   word_idx_t        r_asm_cnt;
   logic             r_asm_done;
   logic             r_obuf_vld;
   logic [CNT_W-1:0] r_blk_cnt;

   logic             w_accept;
   logic             w_complete;
   logic             w_obuf_free;
   logic [BLK_W-1:0] w_merged;

   assign in_ready    = rst && !r_asm_done;
   assign fifo_wr_en  = rst && r_obuf_vld && !fifo_full;
   assign w_accept    = in_valid && in_ready;
   assign w_obuf_free = !r_obuf_vld || fifo_wr_en;
   assign w_complete  = w_accept && ((r_asm_cnt == word_idx_t'(N_WORDS - 1)) || in_last);

   // Slots beyond the incoming word are still zero, so a short block is padded for free.
   genvar gi;
   generate
      for (gi = 0; gi < N_WORDS; gi++) begin : g_slot
         assign w_merged[BLK_W-1-WORD_W*gi -: WORD_W] =
            (r_asm_cnt == word_idx_t'(gi)) ? in_data : r_asm[BLK_W-1-WORD_W*gi -: WORD_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_asm      <= '0;
         r_asm_cnt  <= '0;
         r_asm_done <= 1'b0;
         r_obuf     <= '0;
         r_obuf_vld <= 1'b0;
         r_blk_cnt  <= '0;
      end else begin
         if (fifo_wr_en) begin
            r_obuf_vld <= 1'b0;
            r_blk_cnt  <= r_blk_cnt + CNT_W'(1);
         end
         if (w_complete) begin
            r_asm_cnt <= '0;
            if (w_obuf_free) begin
               r_obuf     <= w_merged;
               r_obuf_vld <= 1'b1;
               r_asm      <= '0;
            end else begin
               r_asm      <= w_merged;
               r_asm_done <= 1'b1;
            end
         end else if (w_accept) begin
            r_asm     <= w_merged;
            r_asm_cnt <= r_asm_cnt + 2'd1;
         end else if (r_asm_done && w_obuf_free) begin
            // Parked block moves up as soon as the output register frees.
            r_obuf     <= r_asm;
            r_obuf_vld <= 1'b1;
            r_asm      <= '0;
            r_asm_cnt  <= '0;
            r_asm_done <= 1'b0;
         end
      end
   end

   assign fifo_data = rst ? r_obuf : '0;
   assign blk_cnt   = r_blk_cnt;
   assign busy      = rst && ((r_asm_cnt != '0) || r_asm_done || r_obuf_vld);

endmodule

// File: tb/tb_aes_word_packer.sv
// Randomised and directed bench for aes_word_packer: a word-list model builds
// expected blocks into a queue; a monitor pops and compares on every FIFO write.
module tb_aes_word_packer;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [31:0]  in_data = '0;
   logic         in_last = 1'b0;
   logic         in_ready;
   logic         fifo_full = 1'b0;
   logic         fifo_wr_en;
   logic [127:0] fifo_data;
   logic [15:0]  blk_cnt;
   logic         busy;

   aes_word_packer #(.WORD_W(32), .BLK_W(128), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_data  (fifo_data),
      .blk_cnt    (blk_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_pass = 0;
   logic [127:0] exp_q[$];
   logic [31:0]  part[$];
   int           n_pushed = 0;
   int           n_written = 0;
   int           cycle = 0;
   int           wr_cycles[$];
   int           stalls = 0;
   int           last_acc_cycle = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Expected block: the words received so far, first word at the top, rest zero.
   function automatic logic [127:0] model_block();
      logic [127:0] b;
      b = '0;
      for (int i = 0; i < part.size(); i++) b[127-32*i -: 32] = part[i];
      return b;
   endfunction

   function automatic void accept_word(input logic [31:0] d, input logic last);
      part.push_back(d);
      last_acc_cycle = cycle;
      if (part.size() == 4 || last) begin
         exp_q.push_back(model_block());
         part.delete();
         n_pushed++;
      end
   endfunction

   initial begin : monitor
      logic [127:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst && fifo_wr_en) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_write: got data %h expected no write", fifo_data);
            end else begin
               e = exp_q.pop_front();
               check("blk_data", fifo_data, e);
               check("blk_cnt_at_write", 128'(blk_cnt), 128'(n_written & 16'hFFFF));
            end
            $display("write %0d at cycle %0d data=%h", n_written, cycle, fifo_data);
            n_written++;
            wr_cycles.push_back(cycle);
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic last);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      #1;
      for (int t = 0; t < 200 && !in_ready; t++) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL send_timeout: in_ready=%0b expected 1 within 200 cycles", in_ready);
      end else begin
         accept_word(d, last);
         $display("word %h last=%0b accepted at cycle %0d", d, last, cycle);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b1;
      fifo_full = 1'b0;
      exp_q.delete();
      part.delete();
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         check("rst_in_ready", 128'(in_ready), 128'(0));
         check("rst_wr_en", 128'(fifo_wr_en), 128'(0));
         check("rst_data", fifo_data, 128'(0));
      end
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_written = 0;
      n_pushed  = 0;
      wr_cycles.delete();
      #1;
      check("rel_in_ready", 128'(in_ready), 128'(1));
      check("rel_blk_cnt", 128'(blk_cnt), 128'(0));
      check("rel_busy", 128'(busy), 128'(0));
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
         @(negedge clk);
         #3;
      end
      @(negedge clk);
      #3;
      check("drain_queue_empty", 128'(exp_q.size()), 128'(0));
      check("drain_blk_cnt", 128'(blk_cnt), 128'(n_pushed & 16'hFFFF));
      check("drain_busy", 128'(busy), 128'(part.size() != 0));
   endtask

   initial begin : stim
      logic [31:0] d;
      logic        l;
      // 1: reset behaviour
      do_reset(3);

      // 2: single block, latency and single-cycle strobe
      send(32'h00010203, 1'b0);
      send(32'h04050607, 1'b0);
      send(32'h08090A0B, 1'b0);
      send(32'h0C0D0E0F, 1'b0);
      idle();
      drain();
      check("t2_one_write", 128'(wr_cycles.size()), 128'(1));
      if (wr_cycles.size() > 0)
         check("t2_latency", 128'(wr_cycles[0]), 128'(last_acc_cycle + 1));

      // 3: streaming 12 words
      do_reset(1);
      stalls = 0;
      for (int i = 1; i <= 12; i++) send(32'(i), 1'b0);
      idle();
      check("t3_no_stall", 128'(stalls), 128'(0));
      drain();
      check("t3_writes", 128'(wr_cycles.size()), 128'(3));
      if (wr_cycles.size() == 3) begin
         check("t3_gap1", 128'(wr_cycles[1] - wr_cycles[0]), 128'(4));
         check("t3_gap2", 128'(wr_cycles[2] - wr_cycles[1]), 128'(4));
      end

      // 4: back-pressure
      do_reset(1);
      fifo_full = 1'b1;
      stalls = 0;
      for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
      check("t4_eight_no_stall", 128'(stalls), 128'(0));
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'd9;
      #1;
      check("t4_held_off", 128'(in_ready), 128'(0));
      check("t4_busy", 128'(busy), 128'(1));
      repeat (3) @(negedge clk);
      #1;
      check("t4_still_held", 128'(in_ready), 128'(0));
      check("t4_no_write_full", 128'(wr_cycles.size()), 128'(0));
      fifo_full = 1'b0;
      stalls = 0;
      send(32'd9, 1'b0);
      check("t4_ninth_after_free", 128'(stalls), 128'(0));
      idle();
      drain();
      check("t4_writes", 128'(wr_cycles.size()), 128'(2));
      if (wr_cycles.size() == 2)
         check("t4_back_to_back", 128'(wr_cycles[1] - wr_cycles[0]), 128'(1));

      // 5: short block with in_last
      do_reset(1);
      send(32'hAAAAAAAA, 1'b0);
      send(32'hBBBBBBBB, 1'b1);
      idle();
      drain();
      check("t5_writes", 128'(wr_cycles.size()), 128'(1));

      // 6: reset mid-block discards the partial
      do_reset(1);
      send(32'h12345678, 1'b0);
      send(32'h9ABCDEF0, 1'b0);
      idle();
      do_reset(1);
      send(32'h11111111, 1'b0);
      send(32'h22222222, 1'b0);
      send(32'h33333333, 1'b0);
      send(32'h44444444, 1'b0);
      idle();
      drain();
      check("t6_writes", 128'(wr_cycles.size()), 128'(1));

      // 7: random traffic with random back-pressure and occasional reset
      do_reset(1);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1);
         end else begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            d         = $urandom;
            l         = ($urandom_range(0, 5) == 0);
            in_data   = d;
            in_last   = l;
            fifo_full = ($urandom_range(0, 9) < 4);
            #1;
            if (in_valid && in_ready) accept_word(d, l);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      fifo_full = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/aes_word_packer.md
Name: aes_word_packer

Overview:
- Upstream feeder for the AES input FIFO (128-bit wide, 8 deep, fifo_width 128).
- Accepts 32-bit words over a valid/ready handshake and assembles them into 128-bit AES blocks, MSW first.
- Writes each completed block into the FIFO with a single-cycle wr_en, honouring the FIFO full flag.
- Double-buffered: one assembly register plus one output register, so it sustains 1 word/cycle while the FIFO is not full.

Parameters:
- WORD_W, 32, input word width; fixed ratio BLK_W/WORD_W = 4.
- BLK_W, 128, block width; must equal the FIFO width.
- CNT_W, 16, width of the written-block counter.

Ports:
- clk  in  1  single system clock; all logic acts on its rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  WORD_W  upstream word.
- in_last  in  1  the current word ends the message; a partial block is zero-padded.
- in_ready  out  1  the packer can accept a word this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_data  out  BLK_W  block to the FIFO data_in.
- blk_cnt  out  CNT_W  count of blocks written; wraps modulo 2^CNT_W.
- busy  out  1  a partial or pending block is held.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Clears asm, asm_cnt, asm_done, obuf, obuf_vld and blk_cnt.
  - in_ready=0, fifo_wr_en=0, fifo_data=0, busy=0 while rst=0.
  - A reset mid-block discards all held data; no write is issued.
- Word acceptance:
  - A word is accepted when in_valid && in_ready.
  - Word k (k=0..3) goes to asm bits [BLK_W-1-32k -: 32]. Word 0 lands in [127:96].
  - Words not written are 0.
- in_ready = rst && !asm_done.
- Completion: an accepted word completes the block when asm_cnt==3 or in_last=1.
  - in_last on word 0 gives a block holding one word plus 96 zero bits.
  - Completed-block handling depends on the output register:
    - If !obuf_vld or fifo_wr_en is high this cycle, the merged block loads obuf on the same edge. obuf_vld=1, asm cleared, asm_cnt=0.
    - Otherwise the block stays in asm, asm_done=1 and in_ready drops.
- asm_done transfer: when asm_done && (!obuf_vld || fifo_wr_en), asm moves to obuf, asm_done=0 and asm_cnt=0.
- Write strobe:
  - fifo_wr_en = rst && obuf_vld && !fifo_full (combinational).
  - fifo_data = obuf.
  - On a write edge: obuf_vld clears unless reloaded that edge, and blk_cnt increments.
- Latency: fifo_wr_en rises the cycle after the completing word is accepted, if fifo_full=0.
- Streaming at fifo_full=0: in_ready stays high continuously; one write per 4 accepted words.
- Back-pressure:
  - With fifo_full=1, at most 2 blocks are held: obuf plus a completed asm.
  - in_ready=0 only while asm_done=1.
- Simultaneous events:
  - A write plus a transfer in the same cycle is legal; blk_cnt increments once.
  - The completing word plus a write of obuf loads the new block directly into obuf.
- Ordering: blocks reach the FIFO strictly in arrival order.
- busy = (asm_cnt!=0) || asm_done || obuf_vld.

Decomposition:
- Package aes_pkg holds:
  - Constants WORD_W=32, BLK_W=128, WORDS_PER_BLK=4.
  - The 2-bit word-index typedef.
  - The block typedef logic[127:0], shared with the FIFO and the AES core.
- No sub-module; the datapath and control fit one module.

Test Plan:
1. rst=0 for 3 cycles, then rst=1:
   - During reset: in_ready=0, fifo_wr_en=0.
   - After release: in_ready=1, blk_cnt=0, busy=0.
2. Words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F on consecutive cycles, fifo_full=0:
   - fifo_wr_en=1 for exactly one cycle, one cycle after the 4th word.
   - fifo_data=0x000102030405060708090A0B0C0D0E0F; then blk_cnt=1.
3. 12 back-to-back words (values 1..12), fifo_full=0:
   - in_ready never drops.
   - 3 writes, 4 cycles apart: 0x00000001...00000004, then ...05..08, then ...09..0C.
   - blk_cnt=3.
4. fifo_full=1, stream 9 words:
   - in_ready drops after the 8th word; the 9th word is held off.
   - Release fifo_full: writes of block 1 then block 2 on consecutive cycles; the 9th word is accepted once asm frees; blk_cnt=2.
5. Words 0xAAAAAAAA, then 0xBBBBBBBB with in_last=1:
   - fifo_data=0xAAAAAAAABBBBBBBB0000000000000000 after one write.
6. Accept 2 words, pulse rst=0 for one cycle, then send 4 new words 0x11111111..0x44444444:
   - No write for the discarded partial.
   - Next write is 0x11111111222222223333333344444444; blk_cnt=1.
